// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered syncs.
// Define VGA_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_W     = 10'(H_SYNC);
  localparam logic [9:0] VS_W     = 10'(V_SYNC);
  localparam logic [9:0] HV_S     = 10'(H_VIS_START);
  localparam logic [9:0] HV_E     = 10'(H_VIS_END);
  localparam logic [9:0] VV_S     = 10'(V_VIS_START);
  localparam logic [9:0] VV_E     = 10'(V_VIS_END);

  logic [9:0] div;
  logic       adv;
  logic       h_last;
  logic       v_last;
  logic       wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  assign adv    = (div == DIV_LAST);
  assign h_last = (hCount == H_LAST);
  assign v_last = (vCount == V_LAST);
  assign wrap   = adv & h_last & v_last;

  // Next raster position; syncs are derived from it so they
  // land on the same edge as the counters.
  always_comb begin
    h_next = hCount + 10'd1;
    v_next = vCount;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : vCount + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div         <= '0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
    end else begin
      div         <= adv ? '0 : div + 10'd1;
      pix_en      <= adv;
      frame_start <= wrap;
      if (adv) begin
        hCount <= h_next;
        vCount <= v_next;
        hSync  <= (h_next >= HS_W);
        vSync  <= (v_next >= VS_W);
        bright <= (h_next >= HV_S) && (h_next < HV_E) &&
                  (v_next >= VV_S) && (v_next < VV_E);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
    end else if (wrap) begin
      fcnt <= fcnt + 16'd1;
    end
  end

  assign frame_cnt = fcnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen against an arithmetic raster model.
// Runs a small-raster instance and a default-parameter instance side by side.
module tb_vga_timing_gen;

  localparam int CD  = 3;
  localparam int HT  = 20;
  localparam int HS  = 3;
  localparam int HVS = 5;
  localparam int HVE = 17;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VVS = 3;
  localparam int VVE = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [9:0]  s_hc, s_vc, d_hc, d_vc;
  logic        s_hs, s_vs, s_br, s_pe, s_fs;
  logic        d_hs, d_vs, d_br, d_pe, d_fs;
  logic [15:0] s_fc, d_fc;

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned t      = 0;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS),
    .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC(VS),
    .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) u_small (
    .clk(clk), .rst(rst),
    .hCount(s_hc), .vCount(s_vc),
    .hSync(s_hs), .vSync(s_vs),
    .bright(s_br), .pix_en(s_pe),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst),
    .hCount(d_hc), .vCount(d_vc),
    .hSync(d_hs), .vSync(d_vs),
    .bright(d_br), .pix_en(d_pe),
    .frame_start(d_fs), .frame_cnt(d_fc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)",
               tag, obs, exp, t);
    end
  endtask

  // Expected outputs from the number of clk edges since reset release.
  task automatic check_set(
    input string p,
    input int cd, input int ht, input int hs,
    input int hvs, input int hve,
    input int vt, input int vs,
    input int vvs, input int vve,
    input logic [9:0] hc, input logic [9:0] vc,
    input logic hsy, input logic vsy, input logic br,
    input logic pe, input logic fs, input logic [15:0] fc);
    int unsigned px;
    int unsigned hx;
    int unsigned vx;
    int unsigned nfr;
    bit tick;
    px   = t / cd;
    hx   = px % ht;
    vx   = (px / ht) % vt;
    nfr  = px / (ht * vt);
    tick = (t != 0) && (t % cd == 0);
    check({p, ".hCount"}, 32'(hc), hx);
    check({p, ".vCount"}, 32'(vc), vx);
    check({p, ".hSync"}, 32'(hsy), 32'(hx >= hs));
    check({p, ".vSync"}, 32'(vsy), 32'(vx >= vs));
    check({p, ".bright"}, 32'(br),
          32'(hx >= hvs && hx < hve && vx >= vvs && vx < vve));
    check({p, ".pix_en"}, 32'(pe), 32'(tick));
    check({p, ".frame_start"}, 32'(fs),
          32'(tick && px != 0 && px % (ht * vt) == 0));
`ifdef VGA_FRAME_CNT_EN
    check({p, ".frame_cnt"}, 32'(fc), nfr % 65536);
`else
    check({p, ".frame_cnt"}, 32'(fc), 32'd0 + 0 * nfr);
`endif
  endtask

  task automatic check_all();
    check_set("small", CD, HT, HS, HVS, HVE, VT, VS, VVS, VVE,
              s_hc, s_vc, s_hs, s_vs, s_br, s_pe, s_fs, s_fc);
    check_set("dflt", 4, 800, 96, 144, 784, 525, 2, 35, 515,
              d_hc, d_vc, d_hs, d_vs, d_br, d_pe, d_fs, d_fc);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) t++;
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b0;
    t = 0;
    #1 check_all();
    repeat (hold) step();
    #2 rst = 1'b1;
  endtask

  initial begin
    #12 check_all();
    rst = 1'b1;
    // Long first run covers a full default-size line and several small frames.
    repeat (4000) step();
    for (int i = 0; i < 6; i++) begin
      async_reset(int'($urandom_range(1, 3)));
      repeat ($urandom_range(50, 1500)) step();
    end
    async_reset(3);
    repeat (3 * HT * VT * CD) step();
`ifdef VGA_FRAME_CNT_EN
    check("three_frames", 32'(s_fc), 32'd3);
`else
    check("three_frames", 32'(s_fc), 32'd0);
`endif
    check("three_frames_pos", {6'd0, s_vc, 6'd0, s_hc}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
